// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with two-flop row synchronizer and scan-level debounce.
// Emits the active-low {col,row} code of a single debounced key plus valid/strobe flags.
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] eightBitButton,
    output logic       validPress,
    output logic       key_strobe
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] LP_DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] LP_DWELL_ONE  = DW'(1);
    localparam logic [NW-1:0] LP_CNT_LAST   = NW'(DEBOUNCE_SCANS - 1);
    localparam logic [NW-1:0] LP_CNT_ONE    = NW'(1);

    localparam logic [1:0] ST_RELEASED   = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_REL_PEND   = 2'd3;

    logic [3:0]    r_sync1, r_sync2;
    logic [1:0]    r_col_idx;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_acc_lows;
    logic [7:0]    r_acc_code;
    logic [1:0]    r_state;
    logic [NW-1:0] r_cnt;
    logic [7:0]    r_cand;
    logic [7:0]    r_button;
    logic          r_valid;
    logic          r_strobe;

    logic          w_sample_en;
    logic          w_scan_done;
    logic [2:0]    w_cur_lows;
    logic [1:0]    w_base_lows;
    logic [2:0]    w_tot_lows;
    logic [7:0]    w_code;
    logic          w_is_key;

    always_comb begin
        case (r_col_idx)
            2'd0:    col_out = 4'b0111;
            2'd1:    col_out = 4'b1011;
            2'd2:    col_out = 4'b1101;
            default: col_out = 4'b1110;
        endcase
    end

    assign w_sample_en = (r_dwell == LP_DWELL_LAST);
    assign w_scan_done = w_sample_en && (r_col_idx == 2'd3);

    // Running low-count saturates at 2: anything past one low is already MULTI.
    always_comb begin
        w_cur_lows = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r_sync2[i]) w_cur_lows = w_cur_lows + 3'd1;
        end
        w_base_lows = (r_col_idx == 2'd0) ? 2'd0 : r_acc_lows;
        w_tot_lows  = {1'b0, w_base_lows} + w_cur_lows;
        w_code      = (w_cur_lows == 3'd1) ? {col_out, r_sync2} : r_acc_code;
        w_is_key    = (w_tot_lows == 3'd1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_col_idx  <= '0;
            r_dwell    <= '0;
            r_acc_lows <= '0;
            r_acc_code <= '1;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
            if (w_sample_en) begin
                r_dwell    <= '0;
                r_col_idx  <= r_col_idx + 2'd1;
                r_acc_lows <= (w_tot_lows > 3'd2) ? 2'd2 : w_tot_lows[1:0];
                r_acc_code <= w_code;
            end else begin
                r_dwell <= r_dwell + LP_DWELL_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_RELEASED;
            r_cnt    <= '0;
            r_cand   <= '1;
            r_button <= '1;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_scan_done) begin
                case (r_state)
                    ST_RELEASED: begin
                        if (w_is_key) begin
                            r_cand <= w_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state  <= ST_PRESSED;
                                r_cnt    <= '0;
                                r_button <= w_code;
                                r_valid  <= 1'b1;
                                r_strobe <= 1'b1;
                            end else begin
                                r_state <= ST_PRESS_PEND;
                                r_cnt   <= LP_CNT_ONE;
                            end
                        end
                    end
                    ST_PRESS_PEND: begin
                        if (w_is_key && (w_code == r_cand)) begin
                            if (r_cnt == LP_CNT_LAST) begin
                                r_state  <= ST_PRESSED;
                                r_cnt    <= '0;
                                r_button <= r_cand;
                                r_valid  <= 1'b1;
                                r_strobe <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + LP_CNT_ONE;
                            end
                        end else if (w_is_key) begin
                            r_cand <= w_code;
                            r_cnt  <= LP_CNT_ONE;
                        end else begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_is_key && (w_code == r_cand)) begin
                            r_cnt <= '0;
                        end else if (DEBOUNCE_SCANS == 1) begin
                            r_state  <= ST_RELEASED;
                            r_cnt    <= '0;
                            r_button <= '1;
                            r_valid  <= 1'b0;
                        end else begin
                            r_state <= ST_REL_PEND;
                            r_cnt   <= LP_CNT_ONE;
                        end
                    end
                    default: begin
                        if (w_is_key && (w_code == r_cand)) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == LP_CNT_LAST) begin
                            r_state  <= ST_RELEASED;
                            r_cnt    <= '0;
                            r_button <= '1;
                            r_valid  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + LP_CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign eightBitButton = r_button;
    assign validPress     = r_valid;
    assign key_strobe     = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3, full scan = 16 cycles).
// A keypad model pulls rows low for pressed keys in the currently strobed column.
module tb_keypad_scanner;

    logic       clk;
    logic       resetn;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] eightBitButton;
    logic       validPress;
    logic       key_strobe;

    logic [15:0] key_mask;
    logic        force_en;
    logic [3:0]  force_val;
    logic [3:0]  w_model;

    int n_checks;
    int n_errors;
    int n_strobe;
    int r_edge;

    localparam logic [15:0] K5  = 16'h0001 << 5;
    localparam logic [15:0] K1  = 16'h0001 << 0;
    localparam logic [15:0] K3  = 16'h0001 << 8;
    localparam logic [15:0] K6  = 16'h0001 << 9;
    localparam logic [15:0] KEQ = 16'h0001 << 11;
    localparam logic [15:0] KPL = 16'h0001 << 12;
    localparam logic [15:0] K0  = 16'h0001 << 7;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .row_in         (row_in),
        .col_out        (col_out),
        .eightBitButton (eightBitButton),
        .validPress     (validPress),
        .key_strobe     (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index = col*4 + row; col c is strobed by col_out[3-c], row r drives row_in[3-r].
    always_comb begin
        w_model = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[3-c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (key_mask[c*4+r]) w_model[3-r] = 1'b0;
                end
            end
        end
    end
    assign row_in = force_en ? force_val : w_model;

    always @(negedge clk) begin
        if (resetn && key_strobe) n_strobe++;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (r_edge < target) begin
            @(posedge clk);
            r_edge++;
        end
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_strobe  = 0;
        r_edge    = 0;
        key_mask  = '0;
        force_en  = 1'b1;
        force_val = 4'hF;
        resetn    = 1'b0;

        // Reset with rows toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            force_val = 4'(i * 5 + 3);
            #1;
        end
        check("rst_col", {4'h0, col_out}, 8'h07);
        check("rst_btn", eightBitButton, 8'hFF);
        check("rst_valid", {7'd0, validPress}, 8'h00);
        check("rst_strobe", {7'd0, key_strobe}, 8'h00);
        @(negedge clk);
        resetn   = 1'b1;
        force_en = 1'b0;
        key_mask = K5;
        r_edge   = 0;

        run_to(1);  check("col_c0", {4'h0, col_out}, 8'h07);
        run_to(5);  check("col_c1", {4'h0, col_out}, 8'h0B);
        run_to(9);  check("col_c2", {4'h0, col_out}, 8'h0D);
        run_to(13); check("col_c3", {4'h0, col_out}, 8'h0E);
        run_to(17); check("col_wrap", {4'h0, col_out}, 8'h07);

        // Clean press of key 5
        run_to(47); check("k5_pre_valid", {7'd0, validPress}, 8'h00);
        run_to(48);
        check("k5_valid", {7'd0, validPress}, 8'h01);
        check("k5_btn", eightBitButton, 8'hBB);
        check("k5_strobe", {7'd0, key_strobe}, 8'h01);
        key_mask = '0;
        run_to(49);
        check("k5_strobe_off", {7'd0, key_strobe}, 8'h00);
        check("k5_hold_btn", eightBitButton, 8'hBB);
        run_to(95); check("k5_rel_pre", {7'd0, validPress}, 8'h01);
        run_to(96);
        check("k5_rel_valid", {7'd0, validPress}, 8'h00);
        check("k5_rel_btn", eightBitButton, 8'hFF);
        check("k5_nstrobe", 8'(n_strobe), 8'd1);

        // Bounce: key 1 on alternating scans
        for (int s = 6; s < 16; s++) begin
            key_mask = (s % 2 == 0) ? K1 : 16'h0000;
            run_to(16 * (s + 1));
            check("bounce_valid", {7'd0, validPress}, 8'h00);
        end
        key_mask = K1;
        run_to(303); check("k1_pre_valid", {7'd0, validPress}, 8'h00);
        run_to(304);
        check("k1_valid", {7'd0, validPress}, 8'h01);
        check("k1_btn", eightBitButton, 8'h77);
        key_mask = '0;
        run_to(320); check("k1_drop_valid", {7'd0, validPress}, 8'h01);
        key_mask = K1;
        run_to(336); check("k1_back_valid", {7'd0, validPress}, 8'h01);
        run_to(352);
        check("k1_back_btn", eightBitButton, 8'h77);
        check("k1_nstrobe", 8'(n_strobe), 8'd2);
        key_mask = '0;
        run_to(399); check("k1_rel_pre", {7'd0, validPress}, 8'h01);
        run_to(400); check("k1_rel_valid", {7'd0, validPress}, 8'h00);

        // Multi-key in one column
        key_mask = K3 | K6;
        for (int s = 25; s < 33; s++) begin
            run_to(16 * (s + 1));
            check("multi_valid", {7'd0, validPress}, 8'h00);
        end
        check("multi_btn", eightBitButton, 8'hFF);
        key_mask = '0;
        run_to(544);

        // Rollover '=' -> '+'
        key_mask = KEQ;
        run_to(592);
        check("eq_valid", {7'd0, validPress}, 8'h01);
        check("eq_btn", eightBitButton, 8'hDE);
        key_mask = KPL;
        run_to(624);
        check("roll_hold_valid", {7'd0, validPress}, 8'h01);
        check("roll_hold_btn", eightBitButton, 8'hDE);
        run_to(640);
        check("roll_rel_valid", {7'd0, validPress}, 8'h00);
        check("roll_rel_btn", eightBitButton, 8'hFF);
        check("roll_nstrobe", 8'(n_strobe), 8'd3);
        run_to(687); check("plus_pre_valid", {7'd0, validPress}, 8'h00);
        run_to(688);
        check("plus_valid", {7'd0, validPress}, 8'h01);
        check("plus_btn", eightBitButton, 8'hE7);
        check("plus_strobe", {7'd0, key_strobe}, 8'h01);
        key_mask = '0;
        run_to(736);
        check("plus_rel_valid", {7'd0, validPress}, 8'h00);
        check("plus_nstrobe", 8'(n_strobe), 8'd4);

        // Reset while key 0 is held
        key_mask = K0;
        run_to(784);
        check("k0_valid", {7'd0, validPress}, 8'h01);
        check("k0_btn", eightBitButton, 8'hBE);
        run_to(790);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_btn", eightBitButton, 8'hFF);
        check("mid_rst_valid", {7'd0, validPress}, 8'h00);
        check("mid_rst_col", {4'h0, col_out}, 8'h07);
        @(negedge clk);
        resetn = 1'b1;
        r_edge = 0;
        run_to(47); check("k0_re_pre", {7'd0, validPress}, 8'h00);
        run_to(48);
        check("k0_re_valid", {7'd0, validPress}, 8'h01);
        check("k0_re_btn", eightBitButton, 8'hBE);
        run_to(50);
        check("k0_re_nstrobe", 8'(n_strobe), 8'd6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
